// File: rtl/commit_trace_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buf_pkg
// Description : Shared types for the commit-stage trace buffer: privilege
//               encoding, record kind, packed trace record and a record
//               packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package commit_trace_buf_pkg;

    localparam int VLEN             = 64;
    localparam int TRACE_DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic {
        TR_INSTR = 1'b0,
        TR_EXC   = 1'b1
    } commit_trace_kind_t;

    typedef struct packed {
        commit_trace_kind_t kind;
        logic [31:0]        cycle;
        logic [VLEN-1:0]    pc;
        priv_lvl_t          priv;
        logic [4:0]         rd;
        logic               we;
        logic               is_fp;
        logic [63:0]        data;
        logic [63:0]        cause;
    } commit_trace_rec_t;

    // Build an INSTR record; data is forced to zero when there is no write-back
    function automatic commit_trace_rec_t make_instr_rec(
        input logic [31:0]     cycle,
        input logic [VLEN-1:0] pc,
        input priv_lvl_t       priv,
        input logic [4:0]      rd,
        input logic            we,
        input logic            is_fp,
        input logic [63:0]     wdata
    );
        commit_trace_rec_t rec;
        rec.kind  = TR_INSTR;
        rec.cycle = cycle;
        rec.pc    = pc;
        rec.priv  = priv;
        rec.rd    = rd;
        rec.we    = we;
        rec.is_fp = is_fp;
        rec.data  = we ? wdata : 64'd0;
        rec.cause = 64'd0;
        return rec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo_2w.sv
`default_nettype none
// ============================================================================
// Module      : trace_fifo_2w
// Description : Two-write, one-read FIFO of trace records. The writer
//               guarantees wr_cnt never exceeds free space; clear empties
//               the FIFO and overrides same-cycle writes and pops.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo_2w
    import commit_trace_buf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      clear,
    input  wire logic [1:0]                wr_cnt,
    input  wire commit_trace_rec_t         wr_data0,
    input  wire commit_trace_rec_t         wr_data1,
    input  wire logic                      rd_en,
    output commit_trace_rec_t              rd_data,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("trace_fifo_2w: DEPTH must be a power of two and at least 4");
        end
    endgenerate

    commit_trace_rec_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic             pop;

    assign wr_ptr_p1 = wr_ptr + 1'b1;
    assign pop       = rd_en && (count != '0);
    assign rd_data   = mem[rd_ptr];

    // Storage array: second write lands in the slot after the first, wrapping
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (wr_cnt != 2'd0) mem[wr_ptr]    <= wr_data0;
            if (wr_cnt == 2'd2) mem[wr_ptr_p1] <= wr_data1;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count  <= count + CNT_W'(wr_cnt) - CNT_W'(pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/commit_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buf
// Description : Commit-stage trace capture. Packs retire/exception events
//               into records, admits them all-or-nothing into a dual-write
//               FIFO, streams them out over valid/ready and counts losses
//               without ever back-pressuring commit.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buf
    import commit_trace_buf_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter int NR_COMMIT_PORTS = 2
) (
    input  wire logic                          clk_i,
    input  wire logic                          rst_ni,
    input  wire logic                          en_i,
    input  wire logic                          clear_i,
    input  wire logic [1:0]                    commit_ack_i,
    input  wire logic [1:0][VLEN-1:0]          commit_pc_i,
    input  wire logic [1:0]                    commit_we_i,
    input  wire logic [1:0]                    commit_fpr_i,
    input  wire logic [1:0][4:0]               commit_waddr_i,
    input  wire logic [1:0][63:0]              commit_wdata_i,
    input  wire priv_lvl_t                     priv_lvl_i,
    input  wire logic                          ex_valid_i,
    input  wire logic [63:0]                   ex_cause_i,
    input  wire logic [63:0]                   ex_tval_i,
    input  wire logic [VLEN-1:0]               ex_pc_i,
    output logic                               trace_valid_o,
    input  wire logic                          trace_ready_i,
    output commit_trace_rec_t                  trace_rec_o,
    output logic [TRACE_DROP_CNT_W-1:0]        dropped_cnt_o,
    output logic                               overflow_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    generate
        if (NR_COMMIT_PORTS != 2) begin : g_ports_check
            $error("commit_trace_buf: NR_COMMIT_PORTS must be 2");
        end
    endgenerate

    logic [31:0]       cycle;
    logic [CNT_W-1:0]  count;
    logic [1:0]        n_req;
    logic              fits;
    logic              drop;
    logic [1:0]        wr_cnt;
    commit_trace_rec_t rec_p0;
    commit_trace_rec_t rec_p1;
    commit_trace_rec_t rec_exc;
    commit_trace_rec_t wr_data0;
    commit_trace_rec_t head;
    logic [TRACE_DROP_CNT_W:0] drop_sum;

    // Free-running timestamp; only reset clears it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cycle <= '0;
        else         cycle <= cycle + 32'd1;
    end

    // Requests this cycle: an exception suppresses the commit ports entirely
    assign n_req = ex_valid_i ? 2'd1
                              : (2'(commit_ack_i[0]) + 2'(commit_ack_i[1]));

    // Admission uses the registered count; a same-cycle pop does not help
    assign fits     = (CNT_W'(DEPTH) - count) >= CNT_W'(n_req);
    assign wr_cnt   = (en_i && fits) ? n_req : 2'd0;
    assign drop     = en_i && !fits && !clear_i;
    assign drop_sum = {1'b0, dropped_cnt_o} + (TRACE_DROP_CNT_W + 1)'(n_req);

    // Record packing; slot 0 takes the exception, port 0, or a lone port 1
    always_comb begin
        rec_p0 = make_instr_rec(cycle, commit_pc_i[0], priv_lvl_i, commit_waddr_i[0],
                                commit_we_i[0], commit_fpr_i[0], commit_wdata_i[0]);
        rec_p1 = make_instr_rec(cycle, commit_pc_i[1], priv_lvl_i, commit_waddr_i[1],
                                commit_we_i[1], commit_fpr_i[1], commit_wdata_i[1]);
        rec_exc       = '0;
        rec_exc.kind  = TR_EXC;
        rec_exc.cycle = cycle;
        rec_exc.pc    = ex_pc_i;
        rec_exc.priv  = priv_lvl_i;
        rec_exc.data  = ex_tval_i;
        rec_exc.cause = ex_cause_i;
        if (ex_valid_i)           wr_data0 = rec_exc;
        else if (commit_ack_i[0]) wr_data0 = rec_p0;
        else                      wr_data0 = rec_p1;
    end

    trace_fifo_2w #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .clear    (clear_i),
        .wr_cnt   (wr_cnt),
        .wr_data0 (wr_data0),
        .wr_data1 (rec_p1),
        .rd_en    (trace_ready_i),
        .rd_data  (head),
        .count    (count)
    );

    assign trace_valid_o = (count != '0);
    assign trace_rec_o   = trace_valid_o ? head : '0;

    // Loss accounting: saturating drop counter and sticky overflow flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dropped_cnt_o <= '0;
            overflow_o    <= 1'b0;
        end else if (clear_i) begin
            dropped_cnt_o <= '0;
            overflow_o    <= 1'b0;
        end else if (drop) begin
            dropped_cnt_o <= drop_sum[TRACE_DROP_CNT_W] ? '1
                                                        : drop_sum[TRACE_DROP_CNT_W-1:0];
            overflow_o    <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_buf
// Description : Directed self-checking bench for commit_trace_buf (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buf;
    import commit_trace_buf_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_ni;
    logic                   en_i;
    logic                   clear_i;
    logic [1:0]             commit_ack_i;
    logic [1:0][VLEN-1:0]   commit_pc_i;
    logic [1:0]             commit_we_i;
    logic [1:0]             commit_fpr_i;
    logic [1:0][4:0]        commit_waddr_i;
    logic [1:0][63:0]       commit_wdata_i;
    priv_lvl_t              priv_lvl_i;
    logic                   ex_valid_i;
    logic [63:0]            ex_cause_i;
    logic [63:0]            ex_tval_i;
    logic [VLEN-1:0]        ex_pc_i;
    logic                   trace_valid_o;
    logic                   trace_ready_i;
    commit_trace_rec_t      trace_rec_o;
    logic [15:0]            dropped_cnt_o;
    logic                   overflow_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] tb_cyc;

    always #5 clk = ~clk;

    // Reference timestamp: counts rising edges since reset was released
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) tb_cyc <= 32'd0;
        else         tb_cyc <= tb_cyc + 32'd1;
    end

    commit_trace_buf #(.DEPTH(8), .NR_COMMIT_PORTS(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .en_i           (en_i),
        .clear_i        (clear_i),
        .commit_ack_i   (commit_ack_i),
        .commit_pc_i    (commit_pc_i),
        .commit_we_i    (commit_we_i),
        .commit_fpr_i   (commit_fpr_i),
        .commit_waddr_i (commit_waddr_i),
        .commit_wdata_i (commit_wdata_i),
        .priv_lvl_i     (priv_lvl_i),
        .ex_valid_i     (ex_valid_i),
        .ex_cause_i     (ex_cause_i),
        .ex_tval_i      (ex_tval_i),
        .ex_pc_i        (ex_pc_i),
        .trace_valid_o  (trace_valid_o),
        .trace_ready_i  (trace_ready_i),
        .trace_rec_o    (trace_rec_o),
        .dropped_cnt_o  (dropped_cnt_o),
        .overflow_o     (overflow_o)
    );

    task automatic idle();
        en_i = 1'b1; clear_i = 1'b0; commit_ack_i = 2'b00;
        commit_pc_i = '0; commit_we_i = 2'b00; commit_fpr_i = 2'b00;
        commit_waddr_i = '0; commit_wdata_i = '0; priv_lvl_i = PRIV_LVL_M;
        ex_valid_i = 1'b0; ex_cause_i = '0; ex_tval_i = '0; ex_pc_i = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic dual(input logic [63:0] pc0, input logic [63:0] pc1);
        commit_ack_i = 2'b11; commit_pc_i[0] = pc0; commit_pc_i[1] = pc1;
        step();
        commit_ack_i = 2'b00;
    endtask

    task automatic test_reset();
        tests++; if (trace_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", trace_valid_o); end
        tests++; if (dropped_cnt_o !== 16'h0) begin fails++; $display("FAIL reset_dropped: got %h expected 0000", dropped_cnt_o); end
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %0b expected 0", overflow_o); end
        tests++; if (trace_rec_o !== '0) begin fails++; $display("FAIL reset_rec: got %h expected 0", trace_rec_o); end
    endtask

    task automatic test_single();
        logic [31:0] exp_cyc;
        trace_ready_i = 1'b1;
        commit_ack_i = 2'b01; commit_pc_i[0] = 64'h8000_0000; commit_we_i[0] = 1'b1;
        commit_waddr_i[0] = 5'd5; commit_wdata_i[0] = 64'h2A; priv_lvl_i = PRIV_LVL_S;
        exp_cyc = tb_cyc;
        step();
        idle();
        tests++; if (trace_valid_o !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b expected 1", trace_valid_o); end
        tests++; if (trace_rec_o.kind !== TR_INSTR) begin fails++; $display("FAIL single_kind: got %0b expected 0", trace_rec_o.kind); end
        tests++; if (trace_rec_o.pc !== 64'h8000_0000) begin fails++; $display("FAIL single_pc: got %h expected 80000000", trace_rec_o.pc); end
        tests++; if (trace_rec_o.data !== 64'h2A || trace_rec_o.rd !== 5'd5 || trace_rec_o.we !== 1'b1) begin fails++; $display("FAIL single_fields: got data %h rd %0d we %0b expected 2a 5 1", trace_rec_o.data, trace_rec_o.rd, trace_rec_o.we); end
        tests++; if (trace_rec_o.cycle !== exp_cyc) begin fails++; $display("FAIL single_cycle: got %0d expected %0d", trace_rec_o.cycle, exp_cyc); end
        tests++; if (trace_rec_o.priv !== PRIV_LVL_S || trace_rec_o.cause !== 64'h0) begin fails++; $display("FAIL single_priv_cause: got %0d %h expected 1 0", trace_rec_o.priv, trace_rec_o.cause); end
        step();
        tests++; if (trace_valid_o !== 1'b0) begin fails++; $display("FAIL single_popped: got %0b expected 0", trace_valid_o); end
    endtask

    task automatic test_dual();
        trace_ready_i = 1'b0;
        commit_we_i = 2'b10; commit_waddr_i[1] = 5'd0; commit_wdata_i[1] = 64'h77;
        commit_wdata_i[0] = 64'hFFFF;
        dual(64'h100, 64'h104);
        idle();
        step();
        tests++; if (trace_rec_o.pc !== 64'h100) begin fails++; $display("FAIL dual_head_stable: got %h expected 100", trace_rec_o.pc); end
        tests++; if (trace_rec_o.data !== 64'h0 || trace_rec_o.we !== 1'b0) begin fails++; $display("FAIL dual_nowe_data: got %h we %0b expected 0 0", trace_rec_o.data, trace_rec_o.we); end
        trace_ready_i = 1'b1;
        step();
        tests++; if (trace_rec_o.pc !== 64'h104) begin fails++; $display("FAIL dual_second: got %h expected 104", trace_rec_o.pc); end
        tests++; if (trace_rec_o.rd !== 5'd0 || trace_rec_o.we !== 1'b1 || trace_rec_o.data !== 64'h77) begin fails++; $display("FAIL dual_x0: got rd %0d we %0b data %h expected 0 1 77", trace_rec_o.rd, trace_rec_o.we, trace_rec_o.data); end
        step();
        tests++; if (trace_valid_o !== 1'b0) begin fails++; $display("FAIL dual_empty: got %0b expected 0", trace_valid_o); end
    endtask

    task automatic test_port1_only();
        trace_ready_i = 1'b0;
        commit_ack_i = 2'b10; commit_pc_i[1] = 64'h300; commit_we_i[1] = 1'b0;
        commit_fpr_i[1] = 1'b1; commit_waddr_i[1] = 5'd3; commit_wdata_i[1] = 64'hFF;
        step();
        idle();
        tests++; if (trace_rec_o.pc !== 64'h300 || trace_rec_o.is_fp !== 1'b1 || trace_rec_o.data !== 64'h0 || trace_rec_o.rd !== 5'd3) begin fails++; $display("FAIL port1_rec: got pc %h fp %0b data %h rd %0d expected 300 1 0 3", trace_rec_o.pc, trace_rec_o.is_fp, trace_rec_o.data, trace_rec_o.rd); end
        trace_ready_i = 1'b1;
        step();
        tests++; if (trace_valid_o !== 1'b0) begin fails++; $display("FAIL port1_single: got %0b expected 0", trace_valid_o); end
    endtask

    task automatic test_exception();
        trace_ready_i = 1'b0;
        ex_valid_i = 1'b1; ex_cause_i = 64'd2; ex_tval_i = 64'hDEAD; ex_pc_i = 64'h200;
        commit_ack_i = 2'b11; commit_pc_i[0] = 64'h500; commit_pc_i[1] = 64'h504;
        step();
        idle();
        tests++; if (trace_rec_o.kind !== TR_EXC || trace_rec_o.pc !== 64'h200) begin fails++; $display("FAIL exc_kind_pc: got %0b %h expected 1 200", trace_rec_o.kind, trace_rec_o.pc); end
        tests++; if (trace_rec_o.data !== 64'hDEAD || trace_rec_o.cause !== 64'd2) begin fails++; $display("FAIL exc_tval_cause: got %h %h expected dead 2", trace_rec_o.data, trace_rec_o.cause); end
        tests++; if (trace_rec_o.we !== 1'b0 || trace_rec_o.rd !== 5'd0) begin fails++; $display("FAIL exc_rd_we: got %0d %0b expected 0 0", trace_rec_o.rd, trace_rec_o.we); end
        trace_ready_i = 1'b1;
        step();
        tests++; if (trace_valid_o !== 1'b0) begin fails++; $display("FAIL exc_only_one: got %0b expected 0", trace_valid_o); end
        tests++; if (dropped_cnt_o !== 16'h0) begin fails++; $display("FAIL exc_no_drop: got %h expected 0000", dropped_cnt_o); end
    endtask

    task automatic test_overflow();
        int n;
        logic [63:0] last_pc;
        trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) dual(64'h1000 + 64'(16 * i), 64'h1004 + 64'(16 * i));
        tests++; if (dropped_cnt_o !== 16'h0) begin fails++; $display("FAIL fill_no_drop: got %h expected 0000", dropped_cnt_o); end
        dual(64'h9000, 64'h9004);
        tests++; if (dropped_cnt_o !== 16'd2 || overflow_o !== 1'b1) begin fails++; $display("FAIL full_drop: got %h ovf %0b expected 0002 1", dropped_cnt_o, overflow_o); end
        tests++; if (trace_rec_o.pc !== 64'h1000) begin fails++; $display("FAIL full_head: got %h expected 1000", trace_rec_o.pc); end
        trace_ready_i = 1'b1;
        step();
        trace_ready_i = 1'b0;
        tests++; if (trace_rec_o.pc !== 64'h1004) begin fails++; $display("FAIL pop_one_head: got %h expected 1004", trace_rec_o.pc); end
        dual(64'hA000, 64'hA004);
        tests++; if (dropped_cnt_o !== 16'd4) begin fails++; $display("FAIL all_or_nothing: got %h expected 0004", dropped_cnt_o); end
        commit_ack_i = 2'b01; commit_pc_i[0] = 64'h2000;
        step();
        tests++; if (dropped_cnt_o !== 16'd4) begin fails++; $display("FAIL single_fits: got %h expected 0004", dropped_cnt_o); end
        commit_pc_i[0] = 64'hB000; trace_ready_i = 1'b1;
        step();
        idle();
        tests++; if (dropped_cnt_o !== 16'd5) begin fails++; $display("FAIL pop_no_free: got %h expected 0005", dropped_cnt_o); end
        n = 0; last_pc = '0;
        for (int i = 0; i < 20; i++) begin
            if (!trace_valid_o) break;
            n++; last_pc = trace_rec_o.pc;
            step();
        end
        tests++; if (n != 7) begin fails++; $display("FAIL drain_count: got %0d expected 7", n); end
        tests++; if (last_pc !== 64'h2000) begin fails++; $display("FAIL drain_last: got %h expected 2000", last_pc); end
    endtask

    task automatic test_saturation();
        trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) dual(64'h40, 64'h44);
        for (int i = 0; i < 32764; i++) dual(64'h50, 64'h54);
        tests++; if (dropped_cnt_o !== 16'd65533) begin fails++; $display("FAIL sat_pre: got %h expected fffd", dropped_cnt_o); end
        dual(64'h60, 64'h64);
        tests++; if (dropped_cnt_o !== 16'hFFFF) begin fails++; $display("FAIL sat_reach: got %h expected ffff", dropped_cnt_o); end
        dual(64'h70, 64'h74);
        tests++; if (dropped_cnt_o !== 16'hFFFF || overflow_o !== 1'b1) begin fails++; $display("FAIL sat_hold: got %h ovf %0b expected ffff 1", dropped_cnt_o, overflow_o); end
    endtask

    task automatic test_clear();
        trace_ready_i = 1'b1; clear_i = 1'b1;
        dual(64'h80, 64'h84);
        idle();
        tests++; if (trace_valid_o !== 1'b0 || dropped_cnt_o !== 16'h0 || overflow_o !== 1'b0) begin fails++; $display("FAIL clear_state: got valid %0b drop %h ovf %0b expected 0 0000 0", trace_valid_o, dropped_cnt_o, overflow_o); end
        step();
        tests++; if (trace_valid_o !== 1'b0) begin fails++; $display("FAIL clear_no_write: got %0b expected 0", trace_valid_o); end
    endtask

    task automatic test_enable();
        trace_ready_i = 1'b0; en_i = 1'b0;
        dual(64'h90, 64'h94);
        ex_valid_i = 1'b1;
        step();
        idle();
        tests++; if (trace_valid_o !== 1'b0 || dropped_cnt_o !== 16'h0) begin fails++; $display("FAIL disabled: got valid %0b drop %h expected 0 0000", trace_valid_o, dropped_cnt_o); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_cyc;
        trace_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) dual(64'hC0, 64'hC4);
        trace_ready_i = 1'b1;
        step();
        tests++; if (trace_valid_o !== 1'b1 || dropped_cnt_o !== 16'd2) begin fails++; $display("FAIL pre_reset: got valid %0b drop %h expected 1 0002", trace_valid_o, dropped_cnt_o); end
        #2 rst_ni = 1'b0;
        #1;
        tests++; if (trace_valid_o !== 1'b0 || trace_rec_o !== '0) begin fails++; $display("FAIL async_reset_out: got valid %0b rec %h expected 0 0", trace_valid_o, trace_rec_o); end
        tests++; if (dropped_cnt_o !== 16'h0 || overflow_o !== 1'b0) begin fails++; $display("FAIL async_reset_cnt: got %h %0b expected 0000 0", dropped_cnt_o, overflow_o); end
        #3 rst_ni = 1'b1;
        step(); step();
        commit_ack_i = 2'b01; commit_pc_i[0] = 64'hD0;
        exp_cyc = tb_cyc;
        step();
        idle();
        tests++; if (trace_rec_o.cycle !== exp_cyc || trace_rec_o.pc !== 64'hD0) begin fails++; $display("FAIL post_reset_rec: got cyc %0d pc %h expected %0d d0", trace_rec_o.cycle, trace_rec_o.pc, exp_cyc); end
    endtask

    initial begin
        rst_ni = 1'b0; trace_ready_i = 1'b0;
        idle();
        #23;
        test_reset();
        rst_ni = 1'b1;
        step();
        test_single();
        test_dual();
        test_port1_only();
        test_exception();
        test_overflow();
        test_saturation();
        test_clear();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/commit_trace_buf.md
# commit_trace_buf

Synthesizable commit-stage trace capture buffer. It sits beside the commit stage and receives the same retire events that feed the simulation-only instruction tracer: up to two committed instructions per cycle, their register write-back, and exceptions. It packs each event into a fixed-format record, stores it in a dual-write FIFO, and streams records out one per cycle over a valid/ready port to an on-chip trace sink. Loss is counted, never stalls commit.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥4
- NR_COMMIT_PORTS, 2: fixed at 2 (elaboration error otherwise)
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; asynchronous, active-low
- en_i  in  1  capture enable
- clear_i  in  1  synchronous clear of FIFO, drop counter, overflow
- commit_ack_i  in  [1:0]  instruction retiring on port i
- commit_pc_i  in  [1:0][riscv::VLEN-1:0]  PC per port
- commit_we_i  in  [1:0]  register write valid (GPR or FPR)
- commit_fpr_i  in  [1:0]  write targets FP register file
- commit_waddr_i  in  [1:0][4:0]  destination register
- commit_wdata_i  in  [1:0][63:0]  write-back data
- priv_lvl_i  in  riscv::priv_lvl_t  current privilege
- ex_valid_i  in  1  exception taken this cycle
- ex_cause_i, ex_tval_i  in  64 each  cause / trap value
- ex_pc_i  in  riscv::VLEN  faulting PC
- trace_valid_o  out  1  record available
- trace_ready_i  in  1  sink accepts
- trace_rec_o  out  commit_trace_rec_t  head record
- dropped_cnt_o  out  16  records lost, saturating
- overflow_o  out  1  sticky: at least one loss

## Operation
- Record fields: kind (TR_INSTR=0, TR_EXC=1), cycle[31:0], pc, priv, rd, we, is_fp, data[63:0], cause[63:0].
- INSTR record: data=wdata when we else 0; cause=0. rd, we, is_fp taken from the port. A write to x0 is recorded with we=1 and data as given.
- EXC record: data=tval, cause=cause, pc=ex_pc_i, rd=0, we=0, is_fp=0.
- Requests per cycle (n): if ex_valid_i, n=1 (EXC only); the same-cycle commit_ack bits are ignored and not counted. Otherwise n=popcount(commit_ack_i), written port0 then port1.
- Admission is all-or-nothing. When DEPTH−count ≥ n (using the registered count; a same-cycle pop does not free space), all n records are written. Otherwise none are written, dropped_cnt += n saturating at 0xFFFF, and overflow_o is set.
- en_i=0: no writes, no drop accounting; output side keeps draining.
- Pop on trace_valid_o && trace_ready_i. trace_valid_o = (count≠0). trace_rec_o = mem[rd_ptr].
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1. Next count = count + writes − pop.
- cycle: 32-bit free-running counter, cleared at reset, wraps. It is not affected by clear_i. Records carry the value in their write cycle.
- clear_i empties the FIFO (pointers and count to 0) and zeroes dropped_cnt_o and overflow_o. It overrides same-cycle writes and the pop; those writes are not counted as drops.

## Timing
- Reset values: trace_valid_o=0, dropped_cnt_o=0, overflow_o=0, trace_rec_o=0 (memory is not reset; output is gated to 0 when empty), pointers, count and cycle = 0.
- Latency: an event at edge k appears at trace_valid_o after edge k. Throughput: 1 record/cycle out, 2 in.
- Handshake: trace_rec_o is stable while valid && !ready. valid does not depend combinationally on ready.
- Simultaneous pop and write on a full FIFO with n≥1: the write drops, the pop proceeds.
- Reset mid-stream: all state cleared immediately; in-flight records are lost and not counted.

## Structure
- ariane_pkg: commit_trace_kind_t enum, commit_trace_rec_t packed struct, TRACE_DROP_CNT_W=16.
- One sub-module, trace_fifo_2w: a two-write, one-read FIFO with wr_cnt (0..2), rd_en, count output and clear. commit_trace_buf keeps record packing, admission, counters and the cycle timer.

## Test plan
- Single commit, pc=0x8000_0000, we=1, rd=5, wdata=0x2A, ready=1 → one INSTR record next cycle, data=0x2A, cycle=k; valid low after pop.
- Dual commit in the same cycle, pcs 0x100/0x104, ready=0 → count=2. Raise ready → 0x100 then 0x104 on consecutive cycles.
- Exception with commit_ack=2'b11 in the same cycle, cause=2, tval=0xDEAD → exactly one EXC record; dropped_cnt_o stays 0.
- DEPTH=8, ready=0: 4 dual-commit cycles fill the FIFO; a 5th dual commit → nothing written, dropped_cnt=2, overflow_o=1. With count=7, a dual commit → both dropped (all-or-nothing).
- Saturation: force 0xFFFF drops, then one more → dropped_cnt stays 0xFFFF. clear_i → count, dropped_cnt and overflow all 0, valid=0.
- en_i=0 with commits present → no records, no drops. Assert rst_ni low mid-drain → all outputs return to reset values asynchronously.
